tawas_regfile: RTL
==================

// Module: tawas_regfile
// PURPOSE
//  Per-thread register file feeding the arithmetic unit's A/B operand ports and
//  absorbing its writeback (au_rc_*), plus the load/store writeback path.
//  Holds 4 threads x 8 regs x 32b; thread selected by the 2-bit round-robin slice.
//  Single array write port: AU has priority; a colliding LS write parks in a
//  1-entry pending buffer with ready/valid backpressure and read forwarding.
// PARAMETERS
//  RST_VAL  32'h0  value loaded into every register on reset
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset
//  slice        in   2   current issue slice; read thread = slice
//  ra_sel       in   3   operand A register select (current thread)
//  ra           out  32  operand A data, combinational
//  rb_sel       in   3   operand B register select (current thread)
//  rb           out  32  operand B data, combinational
//  au_rc_vld    in   1   AU writeback valid
//  au_rc_sel    in   3   AU writeback register
//  au_rc        in   32  AU writeback data
//  ls_wr_vld    in   1   LS writeback request
//  ls_wr_rdy    out  1   LS writeback accepted when vld&&rdy
//  ls_wr_thread in   2   LS writeback thread
//  ls_wr_sel    in   3   LS writeback register
//  ls_wr_data   in   32  LS writeback data
//  dbg_sel      in   5   debug read {thread,reg}
//  dbg_data     out  32  debug read data, registered 1 cycle
//  par_err      out  1   parity error pulse (macro only; else 0)
//  par_err_thr  out  2   thread of flagged read (macro only; else 0)
// BEHAVIOUR
//  - Reset: rst asynchronous, active-high; clock clk. All 32 regs=RST_VAL,
//    pend_vld=0, ls_wr_rdy=1, dbg_data=0, par_err=0, par_err_thr=0.
//  - Read: ra/rb = reg[slice][sel], combinational, zero latency; AU samples at edge.
//  - AU write thread = slice+2 (mod 4): AU writeback lands 2 slices after issue.
//    Write commits at posedge when au_rc_vld; next read of that thread
//    (slice+4) sees it, no bypass required for AU path.
//  - Array write arbitration per cycle, priority: AU > pending > new LS.
//    * AU valid: AU writes; accepted new LS captured into pending.
//    * No AU, pend_vld: pending writes, pend_vld<=0; new LS not accepted (rdy=0).
//    * No AU, no pending: accepted LS writes array directly.
//  - ls_wr_rdy = !pend_vld (combinational from flop). Max 1 cycle of stall per
//    collision; continuous AU writes hold pending indefinitely (legal).
//  - Forwarding: if pend_vld && pend_thread==slice && pend_sel==ra_sel, ra=pend
//    data (same for rb). No forwarding from same-cycle AU/LS inputs.
//  - Same reg written by AU and pending in one cycle: AU wins; pending writes next
//    free cycle (later data overwrites) -- LS owns ordering of its own loads.
//  - dbg_data <= reg[dbg_sel[4:3]][dbg_sel[2:0]] every cycle (no forwarding).
//  - Reset mid-collision: pending discarded, rdy returns 1 immediately.
// CONFIGURATION
//  TAWAS_RF_PARITY_EN defined: each reg stores an even-parity bit written with
//   data (pending buffer carries it). On read, mismatch on ra or rb -> par_err=1
//   for exactly 1 cycle after, par_err_thr=slice of that read. Data still returned.
//  Undefined: no parity storage; par_err and par_err_thr tied 0.
// TESTING
//  1. Reset -> ra/rb=RST_VAL for all slices/sels, ls_wr_rdy=1, dbg_data=0.
//  2. slice=0, au_rc_vld, sel=3, data=32'hDEADBEEF -> written to thread 2;
//     slice=2 ra_sel=3 reads 32'hDEADBEEF; thread 0 reg3 still RST_VAL.
//  3. AU write + LS write (thr1,r5,32'h1234) same cycle -> rdy=0 next cycle,
//     thr1 r5 updates one cycle later; slice=1 ra_sel=5 shows 32'h1234
//     during pending via forwarding.
//  4. AU valid 3 consecutive cycles with LS pending -> rdy stays 0, pending
//     drains on 4th cycle; no LS data lost.
//  5. dbg_sel=5'b11_111 after write of 32'hA5A5A5A5 to thr3 r7 -> dbg_data
//     matches one cycle after sel applied.
//  6. PARITY_EN: force-flip bit 0 of thr0 r1, read at slice 0 -> par_err=1
//     for one cycle, par_err_thr=0; without macro par_err stays 0.

Source files
------------

// File: rtl/tawas_regfile.sv
// Per-thread register file (4 threads x 8 regs x 32b) with AU/LS writeback arbitration,
// a 1-entry LS pending buffer with read forwarding, and optional parity (TAWAS_RF_PARITY_EN).
module tawas_regfile #(
   parameter logic [31:0] RST_VAL = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  slice,
   input  logic [2:0]  ra_sel,
   output logic [31:0] ra,
   input  logic [2:0]  rb_sel,
   output logic [31:0] rb,
   input  logic        au_rc_vld,
   input  logic [2:0]  au_rc_sel,
   input  logic [31:0] au_rc,
   input  logic        ls_wr_vld,
   output logic        ls_wr_rdy,
   input  logic [1:0]  ls_wr_thread,
   input  logic [2:0]  ls_wr_sel,
   input  logic [31:0] ls_wr_data,
   input  logic [4:0]  dbg_sel,
   output logic [31:0] dbg_data,
   output logic        par_err,
   output logic [1:0]  par_err_thr
);

   logic [31:0] regs_q [32];
   logic [31:0] regs_d [32];
   logic        pend_vld_q, pend_vld_d;
   logic [4:0]  pend_addr_q, pend_addr_d;
   logic [31:0] pend_data_q, pend_data_d;
   logic [31:0] dbg_data_q, dbg_data_d;

   logic [1:0]  au_thr;
   logic [4:0]  ra_addr, rb_addr;
   logic        ls_acc, fwd_a, fwd_b;
   logic        wr_en, wr_from_pend;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   // AU writeback lands two slices after the issuing slice.
   assign au_thr    = slice + 2'd2;
   assign ra_addr   = {slice, ra_sel};
   assign rb_addr   = {slice, rb_sel};
   assign ls_wr_rdy = !pend_vld_q;
   assign ls_acc    = ls_wr_vld && !pend_vld_q;
   assign fwd_a     = pend_vld_q && (pend_addr_q == ra_addr);
   assign fwd_b     = pend_vld_q && (pend_addr_q == rb_addr);
   assign ra        = fwd_a ? pend_data_q : regs_q[ra_addr];
   assign rb        = fwd_b ? pend_data_q : regs_q[rb_addr];
   assign dbg_data  = dbg_data_q;

   always_comb begin
      wr_en        = 1'b0;
      wr_from_pend = 1'b0;
      wr_addr      = 5'd0;
      wr_data      = 32'd0;
      pend_vld_d   = pend_vld_q;
      pend_addr_d  = pend_addr_q;
      pend_data_d  = pend_data_q;
      if (au_rc_vld) begin
         wr_en   = 1'b1;
         wr_addr = {au_thr, au_rc_sel};
         wr_data = au_rc;
         if (ls_acc) begin
            pend_vld_d  = 1'b1;
            pend_addr_d = {ls_wr_thread, ls_wr_sel};
            pend_data_d = ls_wr_data;
         end
      end else if (pend_vld_q) begin
         wr_en        = 1'b1;
         wr_from_pend = 1'b1;
         wr_addr      = pend_addr_q;
         wr_data      = pend_data_q;
         pend_vld_d   = 1'b0;
      end else if (ls_acc) begin
         wr_en   = 1'b1;
         wr_addr = {ls_wr_thread, ls_wr_sel};
         wr_data = ls_wr_data;
      end
   end

   always_comb begin
      regs_d = regs_q;
      if (wr_en) regs_d[wr_addr] = wr_data;
      dbg_data_d = regs_q[dbg_sel];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= RST_VAL;
         pend_vld_q  <= 1'b0;
         pend_addr_q <= 5'd0;
         pend_data_q <= 32'd0;
         dbg_data_q  <= 32'd0;
      end else begin
         regs_q      <= regs_d;
         pend_vld_q  <= pend_vld_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
         dbg_data_q  <= dbg_data_d;
      end
   end

`ifdef TAWAS_RF_PARITY_EN
   logic        par_q [32];
   logic        par_d [32];
   logic        pend_par_q, pend_par_d;
   logic        exp_par_a, exp_par_b, err;
   logic        par_err_q, par_err_d;
   logic [1:0]  par_err_thr_q, par_err_thr_d;

   // Stored bit makes data^parity even; a forwarded read checks the pending copy.
   assign exp_par_a = fwd_a ? pend_par_q : par_q[ra_addr];
   assign exp_par_b = fwd_b ? pend_par_q : par_q[rb_addr];
   assign err       = ((^ra) != exp_par_a) || ((^rb) != exp_par_b);

   always_comb begin
      par_d      = par_q;
      pend_par_d = pend_par_q;
      if (wr_en) par_d[wr_addr] = wr_from_pend ? pend_par_q : ^wr_data;
      if (au_rc_vld && ls_acc) pend_par_d = ^ls_wr_data;
      par_err_d     = err;
      par_err_thr_d = err ? slice : par_err_thr_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) par_q[i] <= ^RST_VAL;
         pend_par_q    <= 1'b0;
         par_err_q     <= 1'b0;
         par_err_thr_q <= 2'd0;
      end else begin
         par_q         <= par_d;
         pend_par_q    <= pend_par_d;
         par_err_q     <= par_err_d;
         par_err_thr_q <= par_err_thr_d;
      end
   end

   assign par_err     = par_err_q;
   assign par_err_thr = par_err_thr_q;
`else
   assign par_err     = 1'b0;
   assign par_err_thr = 2'd0;
`endif

endmodule
